// File: rtl/servo_pkg.sv
// Shared servo definitions: controller state encoding and default timing constants.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SLEW = 2'd2
  } state_e;

  // Defaults for a 50 MHz clock and a standard 50 Hz hobby servo.
  localparam int SERVO_PERIOD   = 1_000_000;  // 20 ms frame
  localparam int SERVO_MIN_HIGH = 50_000;     // 1 ms
  localparam int SERVO_MAX_HIGH = 100_000;    // 2 ms
  localparam int SERVO_STEP     = 500;        // max change per frame
  localparam int SERVO_CNT_W    = 20;

endpackage

// File: rtl/servo_pwm_gen.sv
// Frame counter and registered PWM comparator for one servo channel.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int PERIOD = SERVO_PERIOD,
  parameter int CNT_W  = SERVO_CNT_W
) (
  input  logic             clock_clk,
  input  logic             reset_low,
  input  logic             enable,
  input  logic [CNT_W-1:0] high_time,
  output logic             pwm_out,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             pwm_q, pwm_d;

  // Next count and next output level; disabling clears both at once,
  // so a pulse in progress is cut on the very next edge.
  always_comb begin
    count_d = '0;
    pwm_d   = 1'b0;
    if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      pwm_d   = (count_q < high_time);
    end
  end

  // Counter and output register.
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      count_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign frame_tick = (count_q == LAST);

endmodule

// File: rtl/servo_slew_ctrl.sv
// Servo position controller: command handshake, clamp, frame-synchronous
// target update and rate-limited slewing of the driven pulse width.
module servo_slew_ctrl
  import servo_pkg::*;
#(
  parameter int PERIOD   = SERVO_PERIOD,
  parameter int MIN_HIGH = SERVO_MIN_HIGH,
  parameter int MAX_HIGH = SERVO_MAX_HIGH,
  parameter int STEP     = SERVO_STEP,
  parameter int CNT_W    = SERVO_CNT_W
) (
  input  logic             clock_clk,
  input  logic             reset_low,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_pos,
  output logic             pwm_out,
  output logic             frame_tick,
  output logic             busy,
  output logic [CNT_W-1:0] active_hi
);

  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] MID_V  = CNT_W'((MIN_HIGH + MAX_HIGH) / 2);
  localparam logic [CNT_W-1:0] STEP_V = CNT_W'(STEP);
  localparam logic [CNT_W:0]   STEP_X = (CNT_W + 1)'(STEP);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] active_hi_q, active_hi_d;
  logic [CNT_W-1:0] pending_pos_q, pending_pos_d;
  logic             pending_q, pending_d;

  logic [CNT_W-1:0] clamp_pos;
  logic [CNT_W-1:0] slewed;
  logic [CNT_W:0]   diff_up, diff_dn;
  logic             gen_tick;
  logic             frame_end;
  logic             accept;

  servo_pwm_gen #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_gen (
    .clock_clk  (clock_clk),
    .reset_low  (reset_low),
    .enable     (enable),
    .high_time  (active_hi_q),
    .pwm_out    (pwm_out),
    .frame_tick (gen_tick)
  );

  // Limit the requested width to the range the servo can physically follow.
  always_comb begin
    clamp_pos = cmd_pos;
    if (cmd_pos < MIN_V) clamp_pos = MIN_V;
    else if (cmd_pos > MAX_V) clamp_pos = MAX_V;
  end

  // One slew step toward the target; the extra bit keeps differences from wrapping.
  always_comb begin
    diff_up = {1'b0, target_q} - {1'b0, active_hi_q};
    diff_dn = {1'b0, active_hi_q} - {1'b0, target_q};
    slewed  = active_hi_q;
    if (active_hi_q < target_q) begin
      slewed = (diff_up > STEP_X) ? active_hi_q + STEP_V : target_q;
    end else if (active_hi_q > target_q) begin
      slewed = (diff_dn > STEP_X) ? active_hi_q - STEP_V : target_q;
    end
  end

  // Next-state logic: width/target change only at frame ends (or at once when idle),
  // and the slew step in a frame-end cycle still uses the outgoing target.
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    active_hi_d   = active_hi_q;
    pending_d     = pending_q;
    pending_pos_d = pending_pos_q;

    frame_end = gen_tick && (state_q != IDLE);
    accept    = cmd_valid && !pending_q;

    if (frame_end) active_hi_d = slewed;

    if (pending_q && (frame_end || state_q == IDLE)) begin
      target_d  = pending_pos_q;
      pending_d = 1'b0;
    end

    if (accept) begin
      pending_d     = 1'b1;
      pending_pos_d = clamp_pos;
    end

    if (!enable)                      state_d = IDLE;
    else if (active_hi_d != target_d) state_d = SLEW;
    else                              state_d = HOLD;
  end

  // Controller registers; reset returns the horn to mid travel.
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q       <= IDLE;
      target_q      <= MID_V;
      active_hi_q   <= MID_V;
      pending_q     <= 1'b0;
      pending_pos_q <= MID_V;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      active_hi_q   <= active_hi_d;
      pending_q     <= pending_d;
      pending_pos_q <= pending_pos_d;
    end
  end

  assign cmd_ready  = !pending_q;
  assign busy       = (active_hi_q != target_q) || pending_q;
  assign active_hi  = active_hi_q;
  assign frame_tick = frame_end;

endmodule
